// File: rtl/alsu_cmd_issuer_if.sv
// Bundle of every signal between the issuer and its neighbours: the command
// stream from the control master, the pin drive to the ALSU and the ALSU
// result coming back, plus the response stream and the error counter.
// The issuer uses the slave view. The master view covers everything outside
// the issuer: the control master, the consumer and the ALSU.
interface alsu_cmd_issuer_if #(
  parameter int TAG_W = 4
);
  // Command stream
  logic             cmd_valid;
  logic             cmd_ready;
  logic [TAG_W-1:0] cmd_tag;
  logic [2:0]       cmd_opcode;
  logic [2:0]       cmd_A;
  logic [2:0]       cmd_B;
  logic             cmd_cin;
  logic             cmd_serial_in;
  logic             cmd_direction;
  logic             cmd_red_op_A;
  logic             cmd_red_op_B;
  logic             cmd_bypass_A;
  logic             cmd_bypass_B;

  // ALSU pin drive and registered ALSU result
  logic [2:0]       alsu_A;
  logic [2:0]       alsu_B;
  logic [2:0]       alsu_opcode;
  logic             alsu_cin;
  logic             alsu_serial_in;
  logic             alsu_direction;
  logic             alsu_red_op_A;
  logic             alsu_red_op_B;
  logic             alsu_bypass_A;
  logic             alsu_bypass_B;
  logic [5:0]       alsu_out;

  // Response stream and error count
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TAG_W-1:0] rsp_tag;
  logic [5:0]       rsp_out;
  logic             rsp_invalid;
  logic [7:0]       err_count;

  modport master (
    output cmd_valid, cmd_tag, cmd_opcode, cmd_A, cmd_B, cmd_cin,
           cmd_serial_in, cmd_direction, cmd_red_op_A, cmd_red_op_B,
           cmd_bypass_A, cmd_bypass_B, alsu_out, rsp_ready,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
           alsu_bypass_B, rsp_valid, rsp_tag, rsp_out, rsp_invalid, err_count
  );

  modport slave (
    input  cmd_valid, cmd_tag, cmd_opcode, cmd_A, cmd_B, cmd_cin,
           cmd_serial_in, cmd_direction, cmd_red_op_A, cmd_red_op_B,
           cmd_bypass_A, cmd_bypass_B, alsu_out, rsp_ready,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_direction, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A,
           alsu_bypass_B, rsp_valid, rsp_tag, rsp_out, rsp_invalid, err_count
  );
endinterface

// File: rtl/alsu_cmd_issuer.sv
// Initiator-side companion to the ALSU. It issues one command per cycle onto
// the ALSU pins and follows each command through the ALSU's two register
// stages. It then captures the matching result into a response FIFO.
// Acceptance is credit-limited: results in flight plus results buffered never
// exceed the FIFO depth, so every result always has a slot to land in.
module alsu_cmd_issuer #(
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  alsu_cmd_issuer_if.slave bus_if
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic             accept;
  logic             cmd_inv;
  logic             push;
  logic             pop;
  logic             rsp_valid;
  logic [1:0]       inflight;
  logic [OCC_W-1:0] occupancy;

  logic             s0_valid_q, s1_valid_q, s2_valid_q;
  logic [TAG_W-1:0] s0_tag_q, s1_tag_q, s2_tag_q;
  logic             s0_inv_q, s1_inv_q, s2_inv_q;

  logic [TAG_W-1:0] tag_mem_q [RSP_DEPTH];
  logic [5:0]       out_mem_q [RSP_DEPTH];
  logic             inv_mem_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [7:0]       err_count_q, err_count_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Invalid-command decode, credit check and handshake qualifiers
  always_comb begin
    cmd_inv   = (bus_if.cmd_opcode[2] & bus_if.cmd_opcode[1]) |
                ((bus_if.cmd_red_op_A | bus_if.cmd_red_op_B) &
                 (bus_if.cmd_opcode[1] | bus_if.cmd_opcode[2]));
    inflight  = 2'(s0_valid_q) + 2'(s1_valid_q) + 2'(s2_valid_q);
    occupancy = OCC_W'(inflight) + OCC_W'(fifo_count_q);
    rsp_valid = (fifo_count_q != '0);
    accept    = bus_if.cmd_valid && !rst && (occupancy < OCC_W'(RSP_DEPTH));
    push      = s2_valid_q;
    pop       = rsp_valid && bus_if.rsp_ready;
  end

  assign bus_if.cmd_ready   = !rst && (occupancy < OCC_W'(RSP_DEPTH));
  assign bus_if.rsp_valid   = rsp_valid;
  assign bus_if.rsp_tag     = rsp_valid ? tag_mem_q[rd_ptr_q] : '0;
  assign bus_if.rsp_out     = rsp_valid ? out_mem_q[rd_ptr_q] : '0;
  assign bus_if.rsp_invalid = rsp_valid ? inv_mem_q[rd_ptr_q] : 1'b0;
  assign bus_if.err_count   = err_count_q;

  // Load the accepted command onto the ALSU pins, otherwise drive a zero NOP
  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      bus_if.alsu_A         <= '0;
      bus_if.alsu_B         <= '0;
      bus_if.alsu_opcode    <= '0;
      bus_if.alsu_cin       <= 1'b0;
      bus_if.alsu_serial_in <= 1'b0;
      bus_if.alsu_direction <= 1'b0;
      bus_if.alsu_red_op_A  <= 1'b0;
      bus_if.alsu_red_op_B  <= 1'b0;
      bus_if.alsu_bypass_A  <= 1'b0;
      bus_if.alsu_bypass_B  <= 1'b0;
    end else begin
      bus_if.alsu_A         <= bus_if.cmd_A;
      bus_if.alsu_B         <= bus_if.cmd_B;
      bus_if.alsu_opcode    <= bus_if.cmd_opcode;
      bus_if.alsu_cin       <= bus_if.cmd_cin;
      bus_if.alsu_serial_in <= bus_if.cmd_serial_in;
      bus_if.alsu_direction <= bus_if.cmd_direction;
      bus_if.alsu_red_op_A  <= bus_if.cmd_red_op_A;
      bus_if.alsu_red_op_B  <= bus_if.cmd_red_op_B;
      bus_if.alsu_bypass_A  <= bus_if.cmd_bypass_A;
      bus_if.alsu_bypass_B  <= bus_if.cmd_bypass_B;
    end
  end

  // Shadow the ALSU pipeline so s2 lines up with the ALSU result register
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s0_inv_q   <= 1'b0;
      s1_inv_q   <= 1'b0;
      s2_inv_q   <= 1'b0;
    end else begin
      s0_valid_q <= accept;
      s0_tag_q   <= accept ? bus_if.cmd_tag : '0;
      s0_inv_q   <= accept & cmd_inv;
      s1_valid_q <= s0_valid_q;
      s1_tag_q   <= s0_tag_q;
      s1_inv_q   <= s0_inv_q;
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_tag_q;
      s2_inv_q   <= s1_inv_q;
    end
  end

  // FIFO storage; the slots need no reset because the head is gated by rsp_valid
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= s2_tag_q;
      out_mem_q[wr_ptr_q] <= bus_if.alsu_out;
      inv_mem_q[wr_ptr_q] <= s2_inv_q;
    end
  end

  // Next occupancy of the FIFO and the saturating error count
  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + 1'b1;
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - 1'b1;
    end
    err_count_d = err_count_q;
    if (accept && cmd_inv && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // FIFO pointers, occupancy and error counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      fifo_count_q <= fifo_count_d;
      err_count_q  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Directed bench for alsu_cmd_issuer. A small behavioural ALSU closes the loop:
// it has registered inputs and a registered output, just like the real block.
// Responses popped by the consumer are logged and compared with hand-computed
// expected values.
module tb_alsu_cmd_issuer;

  localparam int RSP_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic clk;
  logic rst;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [5:0]       out;
    logic             inv;
  } rsp_t;

  rsp_t rspLog[$];

  alsu_cmd_issuer_if #(.TAG_W(TAG_W)) bus_if ();

  alsu_cmd_issuer #(.RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALSU: input registers, then the output register
  logic [2:0] mA, mB, mOp;
  logic       mCin, mSin, mDir, mRa, mRb, mBa, mBb;
  logic [5:0] mOut;

  function automatic logic [5:0] alsuNext(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] op, input logic cin,
                                          input logic sin, input logic dir,
                                          input logic ra, input logic rb,
                                          input logic ba, input logic bb,
                                          input logic [5:0] prev);
    logic [5:0] sa, sb;
    sa = {{3{a[2]}}, a};
    sb = {{3{b[2]}}, b};
    if ((op[2] & op[1]) | ((ra | rb) & (op[1] | op[2]))) return 6'd0;
    if (ba) return sa;
    if (bb) return sb;
    case (op)
      3'd0: return ra ? {5'd0, |a} : (rb ? {5'd0, |b} : (sa | sb));
      3'd1: return ra ? {5'd0, ^a} : (rb ? {5'd0, ^b} : (sa ^ sb));
      3'd2: return sa + sb + {5'd0, cin};
      3'd3: return sa * sb;
      3'd4: return dir ? {prev[4:0], sin} : {sin, prev[5:1]};
      3'd5: return dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mA <= '0; mB <= '0; mOp <= '0;
      mCin <= 1'b0; mSin <= 1'b0; mDir <= 1'b0;
      mRa <= 1'b0; mRb <= 1'b0; mBa <= 1'b0; mBb <= 1'b0;
      mOut <= '0;
    end else begin
      mA   <= bus_if.alsu_A;
      mB   <= bus_if.alsu_B;
      mOp  <= bus_if.alsu_opcode;
      mCin <= bus_if.alsu_cin;
      mSin <= bus_if.alsu_serial_in;
      mDir <= bus_if.alsu_direction;
      mRa  <= bus_if.alsu_red_op_A;
      mRb  <= bus_if.alsu_red_op_B;
      mBa  <= bus_if.alsu_bypass_A;
      mBb  <= bus_if.alsu_bypass_B;
      mOut <= alsuNext(mA, mB, mOp, mCin, mSin, mDir, mRa, mRb, mBa, mBb, mOut);
    end
  end

  assign bus_if.alsu_out = mOut;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  // Log every pop just before the edge that performs it; also watch for overflow
  always begin
    @(negedge clk);
    #4;
    if (!rst && bus_if.rsp_valid && bus_if.rsp_ready)
      rspLog.push_back({bus_if.rsp_tag, bus_if.rsp_out, bus_if.rsp_invalid});
    if (!rst && dut.push && (dut.fifo_count_q == 3'(RSP_DEPTH)) && !dut.pop)
      checkOutput("fifoOverflow", 32'd1, 32'd0);
  end

  task automatic setCmd(input logic [3:0] tag, input logic [2:0] op,
                        input logic [2:0] a, input logic [2:0] b, input logic cin,
                        input logic ra, input logic ba);
    bus_if.cmd_tag       = tag;
    bus_if.cmd_opcode    = op;
    bus_if.cmd_A         = a;
    bus_if.cmd_B         = b;
    bus_if.cmd_cin       = cin;
    bus_if.cmd_serial_in = 1'b0;
    bus_if.cmd_direction = 1'b0;
    bus_if.cmd_red_op_A  = ra;
    bus_if.cmd_red_op_B  = 1'b0;
    bus_if.cmd_bypass_A  = ba;
    bus_if.cmd_bypass_B  = 1'b0;
  endtask

  // Present one command from a negedge; returns at the negedge after its accept
  task automatic applyStimulus(input logic [3:0] tag, input logic [2:0] op,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic cin, input logic ra, input logic ba);
    int waited;
    setCmd(tag, op, a, b, cin, ra, ba);
    bus_if.cmd_valid = 1'b1;
    waited = 0;
    while (!bus_if.cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_if.cmd_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  // Count negedges from the accept until rsp_valid rises (bounded)
  task automatic waitRsp(output int n);
    n = 0;
    while (!bus_if.rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic checkLog(input int idx, input logic [3:0] tag, input logic [5:0] out,
                          input logic inv);
    if (idx < rspLog.size()) begin
      checkOutput($sformatf("logTag%0d", idx), 32'(rspLog[idx].tag), 32'(tag));
      checkOutput($sformatf("logOut%0d", idx), 32'(rspLog[idx].out), 32'(out));
      checkOutput($sformatf("logInv%0d", idx), 32'(rspLog[idx].inv), 32'(inv));
    end else begin
      checkOutput($sformatf("logMissing%0d", idx), 32'(rspLog.size()), 32'(idx + 1));
    end
  endtask

  // Bounded run time
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int idx;
    logic [5:0] bpOut [5];
    bpOut[0] = 6'd1; bpOut[1] = 6'd2; bpOut[2] = 6'd3; bpOut[3] = 6'd4; bpOut[4] = 6'd1;

    rst              = 1'b1;
    bus_if.cmd_valid = 1'b1;
    bus_if.rsp_ready = 1'b0;
    setCmd(4'd9, 3'd2, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);

    // Reset held two cycles with a command waiting
    $display("[TB] reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetCmdReady", 32'(bus_if.cmd_ready), 32'd0);
    checkOutput("resetRspValid", 32'(bus_if.rsp_valid), 32'd0);
    checkOutput("resetRspOut", 32'(bus_if.rsp_out), 32'd0);
    checkOutput("resetAlsuPins", 32'({bus_if.alsu_A, bus_if.alsu_B, bus_if.alsu_opcode,
                bus_if.alsu_cin, bus_if.alsu_serial_in, bus_if.alsu_direction,
                bus_if.alsu_red_op_A, bus_if.alsu_red_op_B, bus_if.alsu_bypass_A,
                bus_if.alsu_bypass_B}), 32'd0);
    checkOutput("resetErrCount", 32'(bus_if.err_count), 32'd0);
    rst              = 1'b0;
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);

    // ADD 3 + 2 + 1 with latency measurement
    $display("[TB] add");
    bus_if.rsp_ready = 1'b1;
    applyStimulus(4'd5, 3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("addPinA", 32'(bus_if.alsu_A), 32'd3);
    waitRsp(n);
    checkOutput("addLatency", 32'(n), 32'd3);
    checkOutput("addOut", 32'(bus_if.rsp_out), 32'd6);
    checkOutput("addTag", 32'(bus_if.rsp_tag), 32'd5);
    checkOutput("addInv", 32'(bus_if.rsp_invalid), 32'd0);
    checkOutput("idlePinsNop", 32'({bus_if.alsu_A, bus_if.alsu_opcode}), 32'd0);
    repeat (3) @(negedge clk);
    rspLog.delete();

    // MULT -4 * -4, then bypass A = -3 back to back
    $display("[TB] mult/bypass");
    applyStimulus(4'd1, 3'd3, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'd2, 3'd0, 3'b101, 3'b000, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checkOutput("multLogSize", 32'(rspLog.size()), 32'd2);
    checkLog(0, 4'd1, 6'b010000, 1'b0);
    checkLog(1, 4'd2, 6'b111101, 1'b0);
    rspLog.delete();

    // Invalid opcode 6, then SHIFT with red_op_A
    $display("[TB] invalid");
    applyStimulus(4'd3, 3'd6, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'd4, 3'd4, 3'd3, 3'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("invErrCount", 32'(bus_if.err_count), 32'd2);
    repeat (6) @(negedge clk);
    checkOutput("invLogSize", 32'(rspLog.size()), 32'd2);
    checkLog(0, 4'd3, 6'd0, 1'b1);
    checkLog(1, 4'd4, 6'd0, 1'b1);
    rspLog.delete();

    // Backpressure: credit limit, then a single pop frees a single slot
    $display("[TB] backpressure");
    bus_if.rsp_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      setCmd(4'(8 + idx), 3'd2, 3'd1, 3'(idx % 4), 1'b0, 1'b0, 1'b0);
      bus_if.cmd_valid = 1'b1;
      if (bus_if.cmd_ready) idx++;
      @(negedge clk);
    end
    checkOutput("bpAccepts", 32'(idx), 32'd4);
    checkOutput("bpCmdReady", 32'(bus_if.cmd_ready), 32'd0);
    checkOutput("bpHeadValid", 32'(bus_if.rsp_valid), 32'd1);
    checkOutput("bpHeadTag", 32'(bus_if.rsp_tag), 32'd8);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      setCmd(4'(8 + idx), 3'd2, 3'd1, 3'(idx % 4), 1'b0, 1'b0, 1'b0);
      if (bus_if.cmd_ready) idx++;
      @(negedge clk);
    end
    checkOutput("bpOneMoreAccept", 32'(idx), 32'd5);
    checkOutput("bpSinglePop", 32'(rspLog.size()), 32'd1);
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("bpLogSize", 32'(rspLog.size()), 32'd5);
    for (int i = 0; i < 5; i++) checkLog(i, 4'(8 + i), bpOut[i], 1'b0);
    rspLog.delete();

    // Reset with two commands in flight, then a fresh ADD 1 + 1
    $display("[TB] reset mid-flight");
    applyStimulus(4'd1, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'd2, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midRstLogSize", 32'(rspLog.size()), 32'd0);
    checkOutput("midRstRspValid", 32'(bus_if.rsp_valid), 32'd0);
    checkOutput("midRstErrCount", 32'(bus_if.err_count), 32'd0);
    applyStimulus(4'd7, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    waitRsp(n);
    checkOutput("postRstLatency", 32'(n), 32'd3);
    checkOutput("postRstOut", 32'(bus_if.rsp_out), 32'd2);
    checkOutput("postRstTag", 32'(bus_if.rsp_tag), 32'd7);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
